reg_bus_arbiter: RTL and testbench

- Sequences transfers on the shared internal register bus (tri-stated by per-register output enables) and shares the bus between several requesters (decode/microcode, interrupt logic, debug port, ...).
- Each transfer moves one source register onto the bus and loads it into a set of destination registers.
- Round-robin arbitration; guarantees at most one output enable is active at any time, so there is no bus contention.

---
 rtl/reg_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
//   Sequences transfers on the shared, tri-stated internal register bus and
//   shares that bus between several requesters with round-robin arbitration.
//   Each transfer drives one source register onto the bus (DRIVE) and then
//   strobes the load lines of a set of destination registers (LOAD). At most
//   one output enable is ever active, so the bus never sees contention.
//
// Ports:
//   clk   in   1          rising-edge clock
//   rst   in   1          asynchronous active-high reset
//   req   in   NREQ       per-requester transfer request (level)
//   src   in   NREQ*SW    per-requester source index, requester i at [i*SW +: SW]
//   dst   in   NREQ*NREG  per-requester load mask, requester i at [i*NREG +: NREG]
//   oe    out  NREG       register output enables (one-hot or zero)
//   load  out  NREG       register load strobes
//   gnt   out  NREQ       one-hot bus owner during DRIVE/LOAD
//   done  out  NREQ       one-cycle completion pulse to the owner
//   err   out  1          pulses with done when the captured src is out of range
//   busy  out  1          high during DRIVE and LOAD
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int NREG = 8,
    parameter int NREQ = 4,
    parameter int SW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SW-1:0]   src,
    input  logic [NREQ*NREG-1:0] dst,
    output logic [NREG-1:0]      oe,
    output logic [NREG-1:0]      load,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREG-1:0] ONE_REG = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] ONE_REQ = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rr;
    logic [RW-1:0]   r_owner;
    logic [SW-1:0]   r_src;
    logic [NREG-1:0] r_dst;
    logic [NREG-1:0] r_oe;
    logic [NREG-1:0] r_load;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_err;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [RW-1:0]   w_rr_nxt;
    logic [RW-1:0]   w_owner_nxt;
    logic [SW-1:0]   w_src_nxt;
    logic [NREG-1:0] w_dst_nxt;
    logic            w_found;
    logic [RW-1:0]   w_win;
    logic [RW-1:0]   w_idx;
    int              w_sum;
    int              w_inc;
    logic [SW-1:0]   w_sel_src;
    logic [NREG-1:0] w_sel_dst;
    logic            w_src_ok;
    logic [NREG-1:0] w_oe_nxt;
    logic [NREG-1:0] w_load_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic            w_err_nxt;
    logic            w_busy_nxt;

    // Round-robin search: first set req bit at or above r_rr, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = int'(r_rr) + k;
            w_idx = RW'((w_sum >= NREQ) ? (w_sum - NREQ) : w_sum);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Select the winner's source index and destination mask.
    always_comb begin
        w_sel_src = '0;
        w_sel_dst = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == RW'(i)) begin
                w_sel_src = src[i*SW +: SW];
                w_sel_dst = dst[i*NREG +: NREG];
            end else begin
                w_sel_src = w_sel_src;
            end
        end
    end

    // Next-state logic; the transfer parameters are frozen at the IDLE->DRIVE edge.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_inc       = int'(r_owner) + 1;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_DRIVE;
                    w_owner_nxt = w_win;
                    w_src_nxt   = w_sel_src;
                    w_dst_nxt   = w_sel_dst;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_rr_nxt    = RW'((w_inc >= NREQ) ? (w_inc - NREQ) : w_inc);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so the outputs themselves are flops.
    always_comb begin
        w_oe_nxt   = '0;
        w_load_nxt = '0;
        w_gnt_nxt  = '0;
        w_done_nxt = '0;
        w_err_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        w_src_ok   = (int'(w_src_nxt) < NREG);
        case (w_state_nxt)
            ST_DRIVE: begin
                w_gnt_nxt  = ONE_REQ << w_owner_nxt;
                w_busy_nxt = 1'b1;
                w_oe_nxt   = w_src_ok ? (ONE_REG << w_src_nxt) : '0;
            end
            ST_LOAD: begin
                w_gnt_nxt  = ONE_REQ << w_owner_nxt;
                w_busy_nxt = 1'b1;
                w_oe_nxt   = w_src_ok ? (ONE_REG << w_src_nxt) : '0;
                w_load_nxt = w_src_ok ? w_dst_nxt : '0;
                w_done_nxt = ONE_REQ << w_owner_nxt;
                w_err_nxt  = !w_src_ok;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // State, captured transfer and registered outputs; reset abandons any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_owner <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_oe    <= '0;
            r_load  <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_oe    <= w_oe_nxt;
            r_load  <= w_load_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign oe   = r_oe;
    assign load = r_load;
    assign gnt  = r_gnt;
    assign done = r_done;
    assign err  = r_err;
    assign busy = r_busy;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_arbiter
//   Self-checking bench for reg_bus_arbiter with NREG=6 so that out-of-range
//   source indices (6, 7) are reachable. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    localparam int NREG = 6;
    localparam int NREQ = 4;
    localparam int SW   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*SW-1:0]   src;
    logic [NREQ*NREG-1:0] dst;
    logic [NREG-1:0]      oe;
    logic [NREG-1:0]      load;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    reg_bus_arbiter #(.NREG(NREG), .NREQ(NREQ), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .src (src),
        .dst (dst),
        .oe  (oe),
        .load(load),
        .gnt (gnt),
        .done(done),
        .err (err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]      req;
        logic [NREQ*SW-1:0]   src;
        logic [NREQ*NREG-1:0] dst;
        logic [NREG-1:0]      oe;
        logic [NREG-1:0]      load;
        logic [NREQ-1:0]      gnt;
        logic [NREQ-1:0]      done;
        logic                 err;
        logic                 busy;
    } vec_t;

    vec_t tbl[$];

    // reference model state (abstract: phase 0 idle, 1 drive, 2 load)
    int m_phase, m_rr, m_owner, m_src;
    logic [NREG-1:0] m_dst;
    int m_grants, dut_grants, dut_dones;
    logic [NREQ-1:0] prev_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ*SW-1:0] ps(input int i, input int s);
        return (NREQ*SW)'(s & 7) << (i * SW);
    endfunction

    function automatic logic [NREQ*NREG-1:0] pd(input int i, input int d);
        return (NREQ*NREG)'(d & 63) << (i * NREG);
    endfunction

    task automatic add(input logic [3:0] r, input logic [11:0] s, input logic [23:0] d,
                       input logic [5:0] e_oe, input logic [5:0] e_ld, input logic [3:0] e_g,
                       input logic [3:0] e_dn, input logic e_er, input logic e_bz);
        vec_t v;
        v.req = r; v.src = s; v.dst = d;
        v.oe = e_oe; v.load = e_ld; v.gnt = e_g; v.done = e_dn; v.err = e_er; v.busy = e_bz;
        tbl.push_back(v);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_oe"}, 32'(oe), 32'd0);
        chk({name, "_load"}, 32'(load), 32'd0);
        chk({name, "_gnt"}, 32'(gnt), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Serve a request set, dropping each requester after its done; checks grant order.
    task automatic rr_seq(input logic [3:0] reqs, input int n, input int e0, input int e1,
                          input int e2, input int e3);
        int exp_o[4];
        int served;
        int budget;
        int got;
        logic [3:0] pend;
        exp_o  = '{e0, e1, e2, e3};
        served = 0;
        budget = 0;
        pend   = reqs;
        src    = '0;
        dst    = '0;
        req    = pend;
        while (served < n && budget < 40) begin
            step();
            budget++;
            if (done != 4'b0000) begin
                got = -1;
                for (int i = 0; i < NREQ; i++) if (done[i]) got = i;
                chk("rr_order", 32'(got), 32'(exp_o[served]));
                if (got >= 0) pend[got] = 1'b0;
                served++;
            end
            req = pend;
        end
        chk("rr_completed", 32'(served), 32'(n));
        req = '0;
        step();
    endtask

    // One random cycle: apply inputs, advance the abstract model, compare everything.
    task automatic rand_cycle(input logic [3:0] r, input logic [11:0] s, input logic [23:0] d);
        logic [NREG-1:0] e_oe, e_ld;
        logic [NREQ-1:0] e_g, e_dn;
        logic e_er, e_bz, ok;
        req = r; src = s; dst = d;
        step();
        if (m_phase == 0) begin
            if (r != 4'b0000) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (r[(m_rr + k) % NREQ]) m_owner = (m_rr + k) % NREQ;
                m_src   = int'((s >> (m_owner * SW)) & 12'd7);
                m_dst   = NREG'(d >> (m_owner * NREG));
                m_phase = 1;
                m_grants++;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_rr    = (m_owner + 1) % NREQ;
            m_phase = 0;
        end
        ok   = (m_src < NREG);
        e_bz = (m_phase != 0);
        e_g  = e_bz ? NREQ'(1 << m_owner) : '0;
        e_oe = (e_bz && ok) ? NREG'(1 << m_src) : '0;
        e_ld = (m_phase == 2 && ok) ? m_dst : '0;
        e_dn = (m_phase == 2) ? e_g : '0;
        e_er = (m_phase == 2) && !ok;
        chk("rand_outputs", 32'({oe, load, gnt, done, err, busy}),
            32'({e_oe, e_ld, e_g, e_dn, e_er, e_bz}));
        chk("oe_onehot0", 32'($countones(oe) <= 1), 32'd1);
        chk("load_only_in_load", 32'((load != '0) && (m_phase != 2)), 32'd0);
        if (gnt != '0 && prev_gnt == '0) dut_grants++;
        if (done != '0) dut_dones++;
        prev_gnt = gnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, with requests present that must be ignored
        rst = 1'b1; req = 4'b1111; src = '0; dst = '1;
        step();
        chk_idle("reset");
        rst = 1'b0; req = '0;
        step();
        chk_idle("idle_after_reset");

        // table: single transfer, invalid source, empty mask, self-load
        add(4'b0001, ps(0,3), pd(0,6'b100001), 6'b001000, 6'b000000, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0001, ps(0,3), pd(0,6'b100001), 6'b001000, 6'b100001, 4'b0001, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, ps(0,3), pd(0,6'b100001), 6'b000000, 6'b000000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b0010, ps(1,7), pd(1,6'h3F),     6'b000000, 6'b000000, 4'b0010, 4'b0000, 1'b0, 1'b1);
        add(4'b0010, ps(1,7), pd(1,6'h3F),     6'b000000, 6'b000000, 4'b0010, 4'b0010, 1'b1, 1'b1);
        add(4'b0000, ps(1,7), pd(1,6'h3F),     6'b000000, 6'b000000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b0100, ps(2,2), pd(2,0),         6'b000100, 6'b000000, 4'b0100, 4'b0000, 1'b0, 1'b1);
        add(4'b0100, ps(2,2), pd(2,0),         6'b000100, 6'b000000, 4'b0100, 4'b0100, 1'b0, 1'b1);
        add(4'b0000, ps(2,2), pd(2,0),         6'b000000, 6'b000000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b1000, ps(3,5), pd(3,6'b100000), 6'b100000, 6'b000000, 4'b1000, 4'b0000, 1'b0, 1'b1);
        add(4'b1000, ps(3,5), pd(3,6'b100000), 6'b100000, 6'b100000, 4'b1000, 4'b1000, 1'b0, 1'b1);
        add(4'b0000, ps(3,5), pd(3,6'b100000), 6'b000000, 6'b000000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int n = 0; n < tbl.size(); n++) begin
            req = tbl[n].req; src = tbl[n].src; dst = tbl[n].dst;
            step();
            chk($sformatf("vec%0d_oe", n), 32'(oe), 32'(tbl[n].oe));
            chk($sformatf("vec%0d_load", n), 32'(load), 32'(tbl[n].load));
            chk($sformatf("vec%0d_gnt", n), 32'(gnt), 32'(tbl[n].gnt));
            chk($sformatf("vec%0d_done", n), 32'(done), 32'(tbl[n].done));
            chk($sformatf("vec%0d_err", n), 32'(err), 32'(tbl[n].err));
            chk($sformatf("vec%0d_busy", n), 32'(busy), 32'(tbl[n].busy));
        end

        // round-robin: all four, then 0 and 3 starting from pointer 0
        rr_seq(4'b1111, 4, 0, 1, 2, 3);
        rr_seq(4'b1001, 2, 0, 3, 0, 0);

        // capture stability: src/dst change during DRIVE is ignored
        req = 4'b0001; src = ps(0,3); dst = pd(0,6'b000011);
        step();
        chk("stab_drive_oe", 32'(oe), 32'(6'b001000));
        src = ps(0,5); dst = pd(0,6'b110000);
        step();
        chk("stab_load_oe", 32'(oe), 32'(6'b001000));
        chk("stab_load_load", 32'(load), 32'(6'b000011));
        req = '0;
        step();

        // reset during LOAD: pointer is 1 here; serve 1 to move it to 2, then abort 2
        rr_seq(4'b0010, 1, 1, 0, 0, 0);
        req = 4'b0100; src = ps(2,1); dst = pd(2,6'h3F);
        step();
        step();
        chk("pre_reset_done", 32'(done), 32'(4'b0100));
        rst = 1'b1;
        #1;
        chk_idle("reset_mid_load");
        step();
        chk_idle("reset_held");
        rst = 1'b0; req = 4'b1010; src = '0; dst = '0;
        step();
        chk("post_reset_gnt", 32'(gnt), 32'(4'b0010));
        chk("post_reset_done", 32'(done), 32'd0);
        step();
        chk("post_reset_load_done", 32'(done), 32'(4'b0010));
        req = '0;
        step();
        step();

        // random traffic against the abstract model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_phase = 0; m_rr = 0; m_owner = 0; m_src = 0; m_dst = '0;
        m_grants = 0; dut_grants = 0; dut_dones = 0; prev_gnt = '0;
        for (int c = 0; c < 10000; c++)
            rand_cycle(4'($urandom_range(0, 15)), 12'($urandom), 24'($urandom));
        for (int c = 0; c < 3; c++)
            rand_cycle(4'b0000, '0, '0);
        chk("done_per_grant", 32'(dut_dones), 32'(dut_grants));
        chk("model_grants", 32'(dut_grants), 32'(m_grants));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
